stopwatch_core: RTL and testbench

- Parametrised stopwatch/timer core that replaces the fixed seconds counter in the top level.
- Generates its own second tick from clk and keeps time as four BCD digits MM:SS, plus a binary total-seconds value for the display path.
- Adds the following:
  - run/pause toggle;
  - clear;
  - digit adjust/load;
  - count-down mode with a done flag;
  - wrap or saturate at the maximum count;
  - a blink strobe for the adjusted digit.
- Sits between the debounce instances and display.

---
 rtl/stopwatch_if.sv | 27 ++
 rtl/stopwatch_core.sv | 194 +++++++++++++++++++
 tb/tb_stopwatch_core.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
// Control and display bundle of the stopwatch core: button/adjust inputs in,
// BCD time, binary seconds and status flags out.
interface stopwatch_if;
    logic        btn_clear;
    logic        btn_run;
    logic        adj;
    logic [1:0]  sel;
    logic [3:0]  num;
    logic        load;
    logic        down;
    logic [15:0] digits;
    logic [12:0] seconds;
    logic        running;
    logic        done;
    logic        blink;
    logic        tick;

    modport master (
        output btn_clear, btn_run, adj, sel, num, load, down,
        input  digits, seconds, running, done, blink, tick
    );

    modport slave (
        input  btn_clear, btn_run, adj, sel, num, load, down,
        output digits, seconds, running, done, blink, tick
    );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch/timer with run/pause, clear, digit load, count-down with a
// done flag, wrap-or-saturate at 99:59 and a blink phase for the edited digit.
module stopwatch_core #(
    parameter int CLK_DIV   = 100000000,
    parameter int BLINK_DIV = 25000000,
    parameter bit WRAP      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    stopwatch_if.slave sw
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [15:0]   MAX_TIME   = 16'h9959;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q;
    logic [15:0]   digits_q;
    logic [12:0]   seconds_q;
    logic [PW-1:0] pre_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic          running_q;
    logic          done_q;
    logic          tick_q;

    logic [15:0]   loaded_d;
    logic [15:0]   inc_d;
    logic [15:0]   dec_d;
    logic          strobe;

    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [3:0] s0, s1, m0, m1;
        {m1, m0, s1, s0} = d;
        if (s0 != 4'd9) s0 = s0 + 4'd1;
        else begin
            s0 = 4'd0;
            if (s1 != 4'd5) s1 = s1 + 4'd1;
            else begin
                s1 = 4'd0;
                if (m0 != 4'd9) m0 = m0 + 4'd1;
                else begin
                    m0 = 4'd0;
                    m1 = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Borrow mirrors the carry: s1 reloads 5, every other digit reloads 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] s0, s1, m0, m1;
        {m1, m0, s1, s0} = d;
        if (s0 != 4'd0) s0 = s0 - 4'd1;
        else begin
            s0 = 4'd9;
            if (s1 != 4'd0) s1 = s1 - 4'd1;
            else begin
                s1 = 4'd5;
                if (m0 != 4'd0) m0 = m0 - 4'd1;
                else begin
                    m0 = 4'd9;
                    m1 = (m1 == 4'd0) ? 4'd9 : m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [12:0] bcd_to_bin(input logic [15:0] d);
        return 13'(d[15:12]) * 13'd600 + 13'(d[11:8]) * 13'd60
             + 13'(d[7:4]) * 13'd10 + 13'(d[3:0]);
    endfunction

    // Per-digit load value, clamped to the legal range of that digit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_load
        localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
        assign loaded_d[gi*4 +: 4] = (sw.sel == 2'(gi))
                                   ? ((sw.num > LIM) ? LIM : sw.num)
                                   : digits_q[gi*4 +: 4];
    end

    assign inc_d  = bcd_inc(digits_q);
    assign dec_d  = bcd_dec(digits_q);
    assign strobe = (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            seconds_q   <= '0;
            pre_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            seconds_q <= bcd_to_bin(digits_q);

            if (!sw.adj) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end

            if (sw.btn_clear) begin
                digits_q  <= '0;
                done_q    <= 1'b0;
                pre_q     <= '0;
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else if (sw.adj) begin
                if (state_q == RUN) begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
                if (sw.load) begin
                    digits_q <= loaded_d;
                    done_q   <= 1'b0;
                    if (state_q == DONE) state_q <= PAUSE;
                end
            end else if (sw.btn_run) begin
                case (state_q)
                    IDLE, PAUSE: begin
                        if (sw.down && digits_q == 16'h0000) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                            pre_q     <= '0;
                        end
                    end
                    RUN: begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (state_q == RUN) begin
                pre_q <= strobe ? '0 : pre_q + 1'b1;
                if (strobe) begin
                    if (sw.down) begin
                        if (digits_q == 16'h0000) begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            digits_q <= dec_d;
                            tick_q   <= 1'b1;
                            // Reaching zero still shows the tick, then stops.
                            if (dec_d == 16'h0000) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end
                    end else if (digits_q == MAX_TIME) begin
                        if (WRAP) begin
                            digits_q <= '0;
                            tick_q   <= 1'b1;
                        end else begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        digits_q <= inc_d;
                        tick_q   <= 1'b1;
                    end
                end
            end
        end
    end

    assign sw.digits  = digits_q;
    assign sw.seconds = seconds_q;
    assign sw.running = running_q;
    assign sw.done    = done_q;
    assign sw.blink   = blink_q & sw.adj;
    assign sw.tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: WRAP=1 instance carries most scenarios, a WRAP=0
// instance covers saturation; ticks are checked against a queue of expected times.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   tick_cyc = 0;
    int   tick1_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] prev_digits = '0;
    logic        sec_pending = 1'b0;
    logic [12:0] sec_exp = '0;

    stopwatch_if sw0();
    stopwatch_if sw1();

    stopwatch_core #(.CLK_DIV(4), .BLINK_DIV(3), .WRAP(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .sw(sw0)
    );
    stopwatch_core #(.CLK_DIV(4), .BLINK_DIV(3), .WRAP(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    function automatic logic [15:0] bin2bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int bcd2bin(input logic [15:0] d);
        return int'(d[15:12]) * 600 + int'(d[11:8]) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    // Scoreboard: every tick pops one expected time; seconds must lag by one cycle.
    always @(negedge clk) begin
        if (rst_n && sw0.tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick digits=%h", sw0.digits);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (sw0.digits !== e) begin
                    errors++;
                    $display("FAIL tick_digits got=%h exp=%h", sw0.digits, e);
                end
                sec_pending = 1'b1;
                sec_exp = 13'(bcd2bin(e));
            end
            checks++;
            if (sw0.seconds !== 13'(bcd2bin(prev_digits))) begin
                errors++;
                $display("FAIL seconds_lag got=%0d exp=%0d", sw0.seconds, bcd2bin(prev_digits));
            end
        end else if (sec_pending) begin
            sec_pending = 1'b0;
            checks++;
            if (sw0.seconds !== sec_exp) begin
                errors++;
                $display("FAIL seconds_after_tick got=%0d exp=%0d", sw0.seconds, sec_exp);
            end
        end
        if (rst_n && sw1.tick) tick1_cnt++;
        prev_digits = sw0.digits;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run0();
        sw0.btn_run = 1'b1;
        step();
        sw0.btn_run = 1'b0;
    endtask

    task automatic wait_tick(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sw0.tick) begin
                got = 1'b1;
                tick_cyc = cyc_cnt;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL tick_timeout got=none exp=tick within %0d cycles", budget);
        end
    endtask

    task automatic load_time0(input logic [15:0] v);
        sw0.adj = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sw0.sel  = 2'(i);
            sw0.num  = v[i*4 +: 4];
            sw0.load = 1'b1;
            step();
        end
        sw0.load = 1'b0;
        sw0.adj  = 1'b0;
        step();
        checks++;
        if (sw0.digits !== v) begin
            errors++;
            $display("FAIL load_digits got=%h exp=%h", sw0.digits, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({sw0.digits, sw0.seconds, sw0.running, sw0.done, sw0.blink, sw0.tick} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%0d/%b%b%b%b exp=all zero",
                     sw0.digits, sw0.seconds, sw0.running, sw0.done, sw0.blink, sw0.tick);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tick_timing();
        int t0;
        for (int k = 1; k <= 3; k++) exp_q.push_back(bin2bcd(k));
        pulse_run0();
        t0 = cyc_cnt;
        @(negedge clk);
        checks++;
        if (sw0.running !== 1'b1) begin
            errors++;
            $display("FAIL run_start running=%b exp=1", sw0.running);
        end
        for (int k = 1; k <= 3; k++) begin
            wait_tick(10);
            checks++;
            if (tick_cyc - t0 != 4 * k) begin
                errors++;
                $display("FAIL tick_latency got=%0d exp=%0d", tick_cyc - t0, 4 * k);
            end
        end
        pulse_run0();
        @(negedge clk);
        checks++;
        if (sw0.running !== 1'b0) begin
            errors++;
            $display("FAIL pause running=%b exp=0", sw0.running);
        end
    endtask

    task automatic test_carry(input logic [15:0] start, input int exp_sec);
        load_time0(start);
        exp_q.push_back(bin2bcd(bcd2bin(start) + 1));
        pulse_run0();
        wait_tick(10);
        pulse_run0();
        @(negedge clk);
        checks++;
        if (sw0.seconds !== 13'(exp_sec)) begin
            errors++;
            $display("FAIL carry_seconds got=%0d exp=%0d", sw0.seconds, exp_sec);
        end
    endtask

    task automatic test_wrap();
        load_time0(16'h9959);
        exp_q.push_back(16'h0000);
        pulse_run0();
        wait_tick(10);
        checks++;
        if (sw0.running !== 1'b1 || sw0.done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_status running=%b done=%b exp running=1 done=0", sw0.running, sw0.done);
        end
        pulse_run0();
    endtask

    task automatic test_hold();
        logic [15:0] v;
        v = 16'h9959;
        sw1.adj = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sw1.sel  = 2'(i);
            sw1.num  = v[i*4 +: 4];
            sw1.load = 1'b1;
            step();
        end
        sw1.load = 1'b0;
        sw1.adj  = 1'b0;
        step();
        sw1.btn_run = 1'b1;
        step();
        sw1.btn_run = 1'b0;
        repeat (6) step();
        @(negedge clk);
        checks++;
        if (sw1.digits !== 16'h9959 || sw1.done !== 1'b1 || sw1.running !== 1'b0 || tick1_cnt != 0) begin
            errors++;
            $display("FAIL saturate got=%h done=%b running=%b ticks=%0d exp=9959 1 0 0",
                     sw1.digits, sw1.done, sw1.running, tick1_cnt);
        end
        sw1.btn_run = 1'b1;
        step();
        sw1.btn_run = 1'b0;
        repeat (5) step();
        checks++;
        if (sw1.running !== 1'b0 || sw1.digits !== 16'h9959) begin
            errors++;
            $display("FAIL done_ignores_run running=%b digits=%h exp=0 9959", sw1.running, sw1.digits);
        end
    endtask

    task automatic test_countdown();
        sw0.down = 1'b1;
        load_time0(16'h0002);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        pulse_run0();
        wait_tick(10);
        wait_tick(10);
        checks++;
        if (sw0.done !== 1'b1 || sw0.running !== 1'b0) begin
            errors++;
            $display("FAIL countdown_done done=%b running=%b exp=1 0", sw0.done, sw0.running);
        end
        step();
        load_time0(16'h0000);
        checks++;
        if (sw0.done !== 1'b0) begin
            errors++;
            $display("FAIL load_clears_done done=%b exp=0", sw0.done);
        end
        pulse_run0();
        @(negedge clk);
        checks++;
        if (sw0.done !== 1'b1 || sw0.running !== 1'b0) begin
            errors++;
            $display("FAIL zero_start_done done=%b running=%b exp=1 0", sw0.done, sw0.running);
        end
        repeat (6) step();
        sw0.down = 1'b0;
    endtask

    task automatic test_adjust();
        sw0.adj = 1'b1;
        sw0.sel = 2'd1; sw0.num = 4'd9; sw0.load = 1'b1;
        step();
        sw0.sel = 2'd0; sw0.num = 4'd15;
        @(negedge clk);
        checks++;
        if (sw0.digits[7:4] !== 4'd5) begin
            errors++;
            $display("FAIL clamp_s1 got=%0d exp=5", sw0.digits[7:4]);
        end
        step();
        sw0.load = 1'b0;
        @(negedge clk);
        checks++;
        if (sw0.digits[3:0] !== 4'd9) begin
            errors++;
            $display("FAIL clamp_s0 got=%0d exp=9", sw0.digits[3:0]);
        end
        sw0.adj = 1'b0;
        step();
        sw0.adj = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            @(negedge clk);
            checks++;
            if (sw0.blink !== 1'((k / 3) % 2)) begin
                errors++;
                $display("FAIL blink_phase k=%0d got=%b exp=%b", k, sw0.blink, 1'((k / 3) % 2));
            end
        end
        sw0.adj = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (sw0.blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_off got=%b exp=0", sw0.blink);
        end
    endtask

    task automatic test_adj_freeze();
        sw0.btn_clear = 1'b1;
        step();
        sw0.btn_clear = 1'b0;
        pulse_run0();
        step();
        sw0.adj = 1'b1;
        repeat (10) step();
        checks++;
        if (sw0.running !== 1'b0) begin
            errors++;
            $display("FAIL adj_pauses running=%b exp=0", sw0.running);
        end
        sw0.adj = 1'b0;
        repeat (6) step();
        checks++;
        if (sw0.running !== 1'b0 || sw0.digits !== 16'h0000) begin
            errors++;
            $display("FAIL adj_frozen running=%b digits=%h exp=0 0000", sw0.running, sw0.digits);
        end
    endtask

    task automatic test_back_to_back();
        load_time0(16'h0005);
        pulse_run0();
        repeat (3) step();
        sw0.btn_clear = 1'b1;
        sw0.btn_run   = 1'b1;
        step();
        sw0.btn_clear = 1'b0;
        sw0.btn_run   = 1'b0;
        @(negedge clk);
        checks++;
        if (sw0.digits !== 16'h0000 || sw0.running !== 1'b0 || sw0.tick !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority digits=%h running=%b tick=%b exp=0000 0 0",
                     sw0.digits, sw0.running, sw0.tick);
        end
        step();
        checks++;
        if (sw0.seconds !== 13'd0) begin
            errors++;
            $display("FAIL clear_seconds got=%0d exp=0", sw0.seconds);
        end
    endtask

    task automatic test_reset_midrun();
        load_time0(16'h0100);
        exp_q.push_back(16'h0101);
        pulse_run0();
        wait_tick(10);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({sw0.digits, sw0.seconds, sw0.running, sw0.done, sw0.blink, sw0.tick} !== '0) begin
            errors++;
            $display("FAIL reset_midrun got=%h/%0d/%b%b%b%b exp=all zero",
                     sw0.digits, sw0.seconds, sw0.running, sw0.done, sw0.blink, sw0.tick);
        end
        repeat (6) step();
    endtask

    initial begin
        {sw0.btn_clear, sw0.btn_run, sw0.adj, sw0.load, sw0.down} = '0;
        sw0.sel = '0;
        sw0.num = '0;
        {sw1.btn_clear, sw1.btn_run, sw1.adj, sw1.load, sw1.down} = '0;
        sw1.sel = '0;
        sw1.num = '0;

        test_reset();
        test_tick_timing();
        test_carry(16'h0059, 60);
        test_carry(16'h0959, 600);
        test_wrap();
        test_hold();
        test_countdown();
        test_adjust();
        test_adj_freeze();
        test_back_to_back();
        test_reset_midrun();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_ticks got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
